sequ_detect: RTL and testbench
==============================

SEQU_DETECT -- requirements
Module: sequ_detect

Interface
REQ-001 The block SHALL have no parameters; the pattern is fixed at 11010, where the first bit shown is the first bit received.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. Clock and reset are named clk and rst_n.
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data_in  input  1  serial bit stream; one bit is sampled on each rising clk edge.
REQ-006 sout  output  1  detect flag; high for exactly one clk cycle per completed 11010 match.

Function
REQ-007 The block SHALL implement a six-state FSM: S0 (idle), S1 ("1"), S2 ("11"), S3 ("110"), S4 ("1101"), S5 ("11010", match).
REQ-008 Transitions on each rising edge, given as data_in=0 / data_in=1:
- S0: 0 -> S0, 1 -> S1.
- S1: 0 -> S0, 1 -> S2.
REQ-009 Transitions, given as data_in=0 / data_in=1:
- S2: 0 -> S3, 1 -> S2.
- S3: 0 -> S0, 1 -> S4.
REQ-010 Transitions, given as data_in=0 / data_in=1:
- S4: 0 -> S5, 1 -> S2.
- S5: 0 -> S0, 1 -> S1.
REQ-011 Overlap SHALL follow from these transitions: the longest pattern prefix that is a suffix of the received stream is always retained. For example, 1111 is held in S2, and 11011 returns to S2.
REQ-012 Default Moore output: sout = 1 exactly when the state is S5, decoded only from the state register, glitch-free, with no combinational path from data_in.
REQ-013 Moore latency: sout rises on the rising edge that samples the final 0 of the pattern and falls on the next rising edge.
REQ-014 Back-to-back matches SHALL each produce a separate one-cycle pulse.
REQ-015 Unreachable or illegal state encodings SHALL return to S0 on the next rising edge with sout = 0.

Reset
REQ-016 While rst_n = 0, the state SHALL be S0 and sout SHALL be 0, both taking effect immediately, independent of clk.
REQ-017 Reset asserted in the middle of a pattern SHALL discard the partial match; after release, a complete new 11010 is required.
REQ-018 On the first rising edge after rst_n rises, the FSM SHALL sample data_in normally; no extra synchronisation cycle is inserted.

Configuration
REQ-019 Macro SEQU_DETECT_MEALY_EN, when undefined: the Moore output of REQ-012 and REQ-013 applies.
REQ-020 Macro SEQU_DETECT_MEALY_EN, when defined: sout = (state == S4) AND (data_in == 0), combinationally.
- sout is asserted in the cycle before the sampling edge, i.e. one cycle earlier than Moore mode.
- The FSM transitions are unchanged.
- Reset still forces sout = 0.

Verification
REQ-021 Reset with data_in = 1 held, rst_n = 0 for 10 cycles -> sout = 0 and state S0 throughout, including mid-cycle assertion.
REQ-022 Bits applied at the clk falling edge: 1,1,1,1,0,1,0,0,0 -> exactly one sout pulse. In Moore mode it lasts the one cycle after the 7th sampled bit; in Mealy mode it spans the cycle before the 7th bit is sampled.
REQ-023 Bits 1,1,0,1,0,1,1,0,1,0 -> two separate one-cycle pulses, after bits 5 and 10.
REQ-024 Bits 1,1,0,1 followed by rst_n = 0 for one cycle, then 0 -> no pulse.
REQ-025 Bits 1,1,0,0,1,0,1,0 and an all-zero stream -> sout stays 0.
REQ-026 Run 20 random bits before and after the REQ-022 sequence, checked against a reference model -> sout matches every occurrence of 11010 with overlap, with zero mismatches.

Source files
------------

// File: rtl/sequ_detect.sv
// Serial 11010 pattern detector with overlap; Moore output by default.
// Define SEQU_DETECT_MEALY_EN for a combinational Mealy output one cycle earlier.
module sequ_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic sout
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Each state holds the longest pattern prefix that is a suffix of the stream.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = data_in ? S1 : S0;
      S1:      state_d = data_in ? S2 : S0;
      S2:      state_d = data_in ? S2 : S3;
      S3:      state_d = data_in ? S4 : S0;
      S4:      state_d = data_in ? S2 : S5;
      S5:      state_d = data_in ? S1 : S0;
      default: state_d = S0;
    endcase
  end

`ifdef SEQU_DETECT_MEALY_EN
  always_comb begin
    sout = 1'b0;
    if (state_q == S4 && !data_in) begin
      sout = 1'b1;
    end
  end
`else
  // Dedicated flop mirrors "state is S5" so the flag never glitches on multi-bit state changes.
  logic match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= (state_d == S5);
    end
  end

  always_comb begin
    sout = match_q;
  end
`endif

endmodule

// File: tb/tb_sequ_detect.sv
// Self-checking bench for sequ_detect: table vectors, reset corner cases and random
// stream compared against a shift-register reference model through a scoreboard queue.
module tb_sequ_detect;

  logic clk;
  logic rst_n;
  logic data_in;
  logic sout;

`ifdef SEQU_DETECT_MEALY_EN
  localparam bit Mealy = 1'b1;
`else
  localparam bit Mealy = 1'b0;
`endif

  sequ_detect dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .sout    (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  // Reference model: last five bits received, and how many bits since reset.
  logic [4:0] hist_m;
  int         cnt_m;

  task automatic model_reset();
    hist_m = 5'b0;
    cnt_m  = 0;
  endtask

  function automatic logic model_step(input logic b);
    hist_m = {hist_m[3:0], b};
    cnt_m  = cnt_m + 1;
    return (cnt_m >= 5) && (hist_m == 5'b11010);
  endfunction

  task automatic check_out(input string tag);
    logic e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, sout=%b", tag, sout);
    end else begin
      e = exp_q.pop_front();
      if (sout !== e) begin
        n_fail++;
        $display("FAIL %s: sout=%b expected=%b at t=%0t", tag, sout, e, $time);
      end
    end
  endtask

  task automatic expect_now(input logic v, input string tag);
    exp_q.push_back(v);
    check_out(tag);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply_bit(input logic b, input logic exp_v, input string tag);
    data_in = b;
    exp_q.push_back(exp_v);
    if (Mealy) begin
      #1 check_out(tag);
      @(posedge clk);
    end else begin
      @(posedge clk);
      #1 check_out(tag);
    end
    @(negedge clk);
  endtask

  task automatic apply_model(input logic b, input string tag);
    logic e;
    e = model_step(b);
    apply_bit(b, e, tag);
  endtask

  // Called at a falling edge; one cycle of reset, sout checked while asserted.
  task automatic do_reset();
    rst_n = 1'b0;
    #1 expect_now(1'b0, "reset_low");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    int          len;
    logic [15:0] bits;  // first bit applied is bits[len-1]
    logic [15:0] exp;   // sout expected for each applied bit, same ordering
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] seq1;
    logic [8:0]  base;

    vecs[0] = '{"ones_then_match", 9,  16'b111101000,  16'b000000100};
    vecs[1] = '{"back_to_back",    10, 16'b1101011010, 16'b0000100001};
    vecs[2] = '{"near_miss",       8,  16'b11001010,   16'b00000000};
    vecs[3] = '{"all_zero",        16, 16'h0000,       16'h0000};
    vecs[4] = '{"overlap_11011",   8,  16'b11011010,   16'b00000001};
    vecs[5] = '{"hold_1111",       4,  16'b1111,       16'b0000};

    rst_n   = 1'b0;
    data_in = 1'b0;
    model_reset();
    #2 expect_now(1'b0, "reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].len; k++) begin
        apply_bit(vecs[v].bits[vecs[v].len-1-k], vecs[v].exp[vecs[v].len-1-k], vecs[v].name);
      end
      do_reset();
    end

    // Mid-cycle asynchronous reset while the detect flag is high, then data_in=1 held.
    base = 9'b110100000;
    for (int k = 0; k < 4; k++) apply_model(base[8-k], "pre_mid_rst");
    data_in = 1'b0;
    #1 expect_now(Mealy, "flag_before_edge");
    @(posedge clk);
    #1 expect_now(!Mealy, "flag_after_edge");
    #2 rst_n = 1'b0;
    #1 expect_now(1'b0, "async_rst_immediate");
    data_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 expect_now(1'b0, "rst_hold_posedge");
      @(negedge clk);
      #1 expect_now(1'b0, "rst_hold_negedge");
    end
    model_reset();
    rst_n = 1'b1;
    // First edge after release samples normally: a fresh pattern matches on its 5th bit.
    for (int k = 0; k < 5; k++) apply_model(base[8-k], "post_rst_match");

    // Partial 1101 discarded by reset; a following 0 must not complete a match.
    do_reset();
    for (int k = 0; k < 4; k++) apply_model(base[8-k], "partial_1101");
    do_reset();
    apply_model(1'b0, "after_partial_rst");
    apply_model(1'b0, "after_partial_rst2");

    // Random stream around the 111101000 sequence, checked against the model.
    do_reset();
    seq1 = 16'b111101000;
    for (int k = 0; k < 20; k++) apply_model(1'($urandom_range(0, 1)), "rand_pre");
    for (int k = 0; k < 9; k++) apply_model(seq1[8-k], "rand_mid");
    for (int k = 0; k < 20; k++) apply_model(1'($urandom_range(0, 1)), "rand_post");

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
